// File: rtl/wb_pkg.sv
// Shared writeback definitions: default widths, channel index helper and the buffered entry layout.
package wb_pkg;

    localparam int DATA_WIDTH_DEF     = 32;
    localparam int REG_ADDR_WIDTH_DEF = 5;
    localparam int MAX_CH             = 4;
    localparam int CH_IDX_W           = 2;

    typedef struct packed {
        logic [REG_ADDR_WIDTH_DEF-1:0] rd;
        logic [DATA_WIDTH_DEF-1:0]     data;
    } wb_entry_t;

    // Next channel index after idx, wrapping at num_ch.
    function automatic logic [CH_IDX_W-1:0] rr_next(input logic [CH_IDX_W-1:0] idx,
                                                    input int unsigned num_ch);
        logic [CH_IDX_W-1:0] nxt;
        if (32'(idx) + 32'd1 >= num_ch) begin
            nxt = 2'd0;
        end else begin
            nxt = idx + 2'd1;
        end
        return nxt;
    endfunction

endpackage

// File: rtl/wb_chan_fifo.sv
// Per-channel synchronous FIFO with flush; full/empty/count come straight from registered state.
module wb_chan_fifo #(
    parameter int WIDTH = 37,
    parameter int DEPTH = 4
) (
    input  logic                       clk,
    input  logic                       reset_n,
    input  logic                       flush,
    input  logic                       push,
    input  logic                       pop,
    input  logic [WIDTH-1:0]           wdata,
    output logic [WIDTH-1:0]           rdata,
    output logic                       full,
    output logic                       empty,
    output logic [$clog2(DEPTH):0]     count
);

    localparam int PTR_W = $clog2(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [WIDTH-1:0] mem_d [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [PTR_W:0]   cnt_q, cnt_d;
    logic             push_ok_s;
    logic             pop_ok_s;

    assign full      = (cnt_q == (PTR_W+1)'(DEPTH));
    assign empty     = (cnt_q == '0);
    assign count     = cnt_q;
    assign rdata     = mem_q[rd_ptr_q];
    assign push_ok_s = push & ~full;
    assign pop_ok_s  = pop & ~empty;

    // Next-state for storage, pointers and occupancy; flush wins over push and pop.
    always_comb begin
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        cnt_d    = cnt_q;
        if (flush) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            cnt_d    = '0;
        end else begin
            if (push_ok_s) begin
                mem_d[wr_ptr_q] = wdata;
                wr_ptr_d        = wr_ptr_q + PTR_W'(1);
            end else begin
                wr_ptr_d = wr_ptr_q;
            end
            if (pop_ok_s) begin
                rd_ptr_d = rd_ptr_q + PTR_W'(1);
            end else begin
                rd_ptr_d = rd_ptr_q;
            end
            case ({push_ok_s, pop_ok_s})
                2'b10:   cnt_d = cnt_q + (PTR_W+1)'(1);
                2'b01:   cnt_d = cnt_q - (PTR_W+1)'(1);
                default: cnt_d = cnt_q;
            endcase
        end
    end

    // FIFO state registers.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            cnt_q    <= '0;
        end else begin
            mem_q    <= mem_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            cnt_q    <= cnt_d;
        end
    end

endmodule

// File: rtl/wb_multi_arbiter.sv
// Multi-channel writeback: aligns decode rd to each result, buffers per channel and
// round-robin arbitrates onto the single register-file write port.
module wb_multi_arbiter
    import wb_pkg::*;
#(
    parameter int NUM_CH         = 2,
    parameter int DATA_WIDTH     = DATA_WIDTH_DEF,
    parameter int REG_ADDR_WIDTH = REG_ADDR_WIDTH_DEF,
    parameter int FIFO_DEPTH     = 4,
    parameter int RD_DELAY       = 2
) (
    input  logic                             clk,
    input  logic                             reset_n,
    input  logic                             flush,
    input  logic [NUM_CH*REG_ADDR_WIDTH-1:0] dec_rd,
    input  logic [NUM_CH-1:0]                exe_valid,
    input  logic [NUM_CH*DATA_WIDTH-1:0]     exe_data,
    output logic [NUM_CH-1:0]                exe_ready,
    output logic [REG_ADDR_WIDTH-1:0]        wb_addr,
    output logic [DATA_WIDTH-1:0]            wb_data,
    output logic                             wb_en,
    output logic                             busy,
    output logic [NUM_CH-1:0]                ovf_err
);

    localparam int EW    = REG_ADDR_WIDTH + DATA_WIDTH;
    localparam int CNT_W = $clog2(FIFO_DEPTH) + 1;

    typedef struct packed {
        logic [REG_ADDR_WIDTH-1:0] rd;
        logic [DATA_WIDTH-1:0]     data;
    } entry_t;

    logic [REG_ADDR_WIDTH-1:0] rd_pipe_q [NUM_CH][RD_DELAY];
    logic [REG_ADDR_WIDTH-1:0] rd_pipe_d [NUM_CH][RD_DELAY];
    entry_t                    push_entry_s [NUM_CH];
    entry_t                    head_s [NUM_CH];
    entry_t                    head_pad_s [MAX_CH];
    logic [CNT_W-1:0]          count_s [NUM_CH];
    logic [NUM_CH-1:0]         full_s, empty_s, nz_s, push_s, pop_s;
    logic [MAX_CH-1:0]         empty_pad_s;
    logic [CH_IDX_W-1:0]       ptr_q, ptr_d;
    logic [CH_IDX_W-1:0]       idx_s, grant_idx_s;
    logic                      grant_vld_s;
    logic [NUM_CH-1:0]         ovf_q, ovf_d;
    logic                      wb_en_q, wb_en_d;
    logic [REG_ADDR_WIDTH-1:0] wb_addr_q, wb_addr_d;
    logic [DATA_WIDTH-1:0]     wb_data_q, wb_data_d;

    // Destination-register delay pipe, shifted every cycle and cleared on flush.
    always_comb begin
        for (int c = 0; c < NUM_CH; c++) begin
            if (flush) begin
                rd_pipe_d[c][0] = '0;
            end else begin
                rd_pipe_d[c][0] = dec_rd[c*REG_ADDR_WIDTH +: REG_ADDR_WIDTH];
            end
            for (int k = 1; k < RD_DELAY; k++) begin
                if (flush) begin
                    rd_pipe_d[c][k] = '0;
                end else begin
                    rd_pipe_d[c][k] = rd_pipe_q[c][k-1];
                end
            end
        end
    end

    // Push qualification and sticky overflow; x0 results vanish without side effects.
    always_comb begin
        ovf_d = ovf_q;
        for (int c = 0; c < NUM_CH; c++) begin
            push_entry_s[c].rd   = rd_pipe_q[c][RD_DELAY-1];
            push_entry_s[c].data = exe_data[c*DATA_WIDTH +: DATA_WIDTH];
            if (exe_valid[c] && !flush && (rd_pipe_q[c][RD_DELAY-1] != '0)) begin
                push_s[c] = ~full_s[c];
                ovf_d[c]  = ovf_q[c] | full_s[c];
            end else begin
                push_s[c] = 1'b0;
                ovf_d[c]  = ovf_q[c];
            end
        end
    end

    for (genvar g = 0; g < NUM_CH; g++) begin : g_fifo
        wb_chan_fifo #(
            .WIDTH (EW),
            .DEPTH (FIFO_DEPTH)
        ) u_fifo (
            .clk     (clk),
            .reset_n (reset_n),
            .flush   (flush),
            .push    (push_s[g]),
            .pop     (pop_s[g]),
            .wdata   (push_entry_s[g]),
            .rdata   (head_s[g]),
            .full    (full_s[g]),
            .empty   (empty_s[g]),
            .count   (count_s[g])
        );
        assign nz_s[g] = (count_s[g] != '0);
    end

    // Round-robin search starting after the last granted channel; unused slots read as empty.
    always_comb begin
        empty_pad_s = 4'b1111;
        for (int c = 0; c < MAX_CH; c++) begin
            head_pad_s[c] = '0;
        end
        for (int c = 0; c < NUM_CH; c++) begin
            empty_pad_s[c] = empty_s[c];
            head_pad_s[c]  = head_s[c];
        end
        grant_vld_s = 1'b0;
        grant_idx_s = ptr_q;
        idx_s       = ptr_q;
        for (int k = 0; k < NUM_CH; k++) begin
            idx_s = rr_next(idx_s, NUM_CH);
            if (!grant_vld_s && !empty_pad_s[idx_s] && !flush) begin
                grant_vld_s = 1'b1;
                grant_idx_s = idx_s;
            end else begin
                grant_vld_s = grant_vld_s;
            end
        end
        for (int c = 0; c < NUM_CH; c++) begin
            pop_s[c] = grant_vld_s && (grant_idx_s == 2'(c));
        end
    end

    // Write-port next state: data holds when idle so the register file sees stable values.
    always_comb begin
        if (grant_vld_s) begin
            wb_en_d   = 1'b1;
            wb_addr_d = head_pad_s[grant_idx_s].rd;
            wb_data_d = head_pad_s[grant_idx_s].data;
            ptr_d     = grant_idx_s;
        end else begin
            wb_en_d   = 1'b0;
            wb_addr_d = wb_addr_q;
            wb_data_d = wb_data_q;
            ptr_d     = ptr_q;
        end
    end

    // Pipe, pointer, error and output registers.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int c = 0; c < NUM_CH; c++) begin
                for (int k = 0; k < RD_DELAY; k++) begin
                    rd_pipe_q[c][k] <= '0;
                end
            end
            ptr_q     <= 2'(NUM_CH-1);
            ovf_q     <= '0;
            wb_en_q   <= 1'b0;
            wb_addr_q <= '0;
            wb_data_q <= '0;
        end else begin
            rd_pipe_q <= rd_pipe_d;
            ptr_q     <= ptr_d;
            ovf_q     <= ovf_d;
            wb_en_q   <= wb_en_d;
            wb_addr_q <= wb_addr_d;
            wb_data_q <= wb_data_d;
        end
    end

    assign exe_ready = ~full_s;
    assign busy      = |nz_s;
    assign ovf_err   = ovf_q;
    assign wb_en     = wb_en_q;
    assign wb_addr   = wb_addr_q;
    assign wb_data   = wb_data_q;

endmodule

// File: tb/tb_wb_multi_arbiter.sv
// Directed self-checking bench for wb_multi_arbiter with two channels, depth 4, rd delay 2.
module tb_wb_multi_arbiter;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        flush;
    logic [9:0]  dec_rd;
    logic [1:0]  exe_valid;
    logic [63:0] exe_data;
    logic [1:0]  exe_ready;
    logic [4:0]  wb_addr;
    logic [31:0] wb_data;
    logic        wb_en;
    logic        busy;
    logic [1:0]  ovf_err;

    int n_cmp = 0;
    int n_err = 0;

    wb_multi_arbiter #(
        .NUM_CH(2), .DATA_WIDTH(32), .REG_ADDR_WIDTH(5), .FIFO_DEPTH(4), .RD_DELAY(2)
    ) dut (
        .clk(clk), .reset_n(reset_n), .flush(flush), .dec_rd(dec_rd),
        .exe_valid(exe_valid), .exe_data(exe_data), .exe_ready(exe_ready),
        .wb_addr(wb_addr), .wb_data(wb_data), .wb_en(wb_en), .busy(busy), .ovf_err(ovf_err)
    );

    always #5 clk = ~clk;

    task automatic apply(input logic [4:0] r0, input logic v0, input logic [31:0] d0,
                         input logic [4:0] r1, input logic v1, input logic [31:0] d1,
                         input logic f);
        dec_rd    = {r1, r0};
        exe_valid = {v1, v0};
        exe_data  = {d1, d0};
        flush     = f;
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        apply(5'd0, 1'b0, 32'd0, 5'd0, 1'b0, 32'd0, 1'b0);
    endtask

    task automatic do_reset();
        reset_n = 1'b0;
        idle();
        idle();
        reset_n = 1'b1;
    endtask

    task automatic test_reset();
        reset_n = 1'b0; flush = 1'b0; dec_rd = '0; exe_valid = '0; exe_data = '0;
        idle();
        idle();
        n_cmp++; if (wb_en !== 1'b0)    begin n_err++; $display("FAIL reset_wb_en got %b want 0", wb_en); end
        n_cmp++; if (wb_addr !== 5'd0)  begin n_err++; $display("FAIL reset_wb_addr got %0d want 0", wb_addr); end
        n_cmp++; if (wb_data !== 32'd0) begin n_err++; $display("FAIL reset_wb_data got %h want 0", wb_data); end
        n_cmp++; if (exe_ready !== 2'b11 || busy !== 1'b0 || ovf_err !== 2'b00) begin
            n_err++; $display("FAIL reset_status got ready=%b busy=%b ovf=%b want 11 0 00", exe_ready, busy, ovf_err);
        end
        reset_n = 1'b1;
    endtask

    task automatic test_single();
        apply(5'd5, 1'b0, 32'd0, 5'd0, 1'b0, 32'd0, 1'b0);
        idle();
        apply(5'd0, 1'b1, 32'hDEAD_BEEF, 5'd0, 1'b0, 32'd0, 1'b0);
        n_cmp++; if (wb_en !== 1'b0 || busy !== 1'b1) begin
            n_err++; $display("FAIL single_after_push got en=%b busy=%b want 0 1", wb_en, busy);
        end
        idle();
        n_cmp++; if (wb_en !== 1'b1 || wb_addr !== 5'd5 || wb_data !== 32'hDEAD_BEEF) begin
            n_err++; $display("FAIL single_write got en=%b addr=%0d data=%h want 1 5 deadbeef", wb_en, wb_addr, wb_data);
        end
        n_cmp++; if (busy !== 1'b0) begin n_err++; $display("FAIL single_busy got %b want 0", busy); end
        idle();
        n_cmp++; if (wb_en !== 1'b0 || wb_addr !== 5'd5 || wb_data !== 32'hDEAD_BEEF) begin
            n_err++; $display("FAIL single_hold got en=%b addr=%0d data=%h want 0 5 deadbeef", wb_en, wb_addr, wb_data);
        end
    endtask

    task automatic test_x0();
        do_reset();
        idle();
        idle();
        apply(5'd0, 1'b1, 32'hCAFE_0000, 5'd0, 1'b0, 32'd0, 1'b0);
        n_cmp++; if (busy !== 1'b0 || exe_ready !== 2'b11 || ovf_err !== 2'b00) begin
            n_err++; $display("FAIL x0_state got busy=%b ready=%b ovf=%b want 0 11 00", busy, exe_ready, ovf_err);
        end
        idle();
        n_cmp++; if (wb_en !== 1'b0) begin n_err++; $display("FAIL x0_wb_en got %b want 0", wb_en); end
    endtask

    task automatic test_round_robin();
        logic [4:0] r0s [3];
        logic [4:0] r1s [3];
        logic [4:0] exp_rd [6];
        logic [4:0] r0, r1;
        logic [31:0] d0, d1;
        logic v;
        r0s = '{5'd1, 5'd2, 5'd3};
        r1s = '{5'd9, 5'd10, 5'd11};
        exp_rd = '{5'd1, 5'd9, 5'd2, 5'd10, 5'd3, 5'd11};
        do_reset();
        for (int k = 0; k < 9; k++) begin
            r0 = (k < 3) ? r0s[k] : 5'd0;
            r1 = (k < 3) ? r1s[k] : 5'd0;
            v  = (k >= 2 && k <= 4);
            d0 = 32'd0; d1 = 32'd0;
            if (v) begin
                d0 = 32'h1000_0000 + 32'(r0s[k-2]);
                d1 = 32'h1000_0000 + 32'(r1s[k-2]);
            end
            apply(r0, v, d0, r1, v, d1, 1'b0);
            if (k >= 3) begin
                n_cmp++;
                if (wb_en !== 1'b1 || wb_addr !== exp_rd[k-3] || wb_data !== 32'h1000_0000 + 32'(exp_rd[k-3])) begin
                    n_err++; $display("FAIL rr_order[%0d] got en=%b addr=%0d data=%h want 1 %0d", k-3, wb_en, wb_addr, wb_data, exp_rd[k-3]);
                end
            end
        end
        idle();
        n_cmp++; if (wb_en !== 1'b0 || busy !== 1'b0) begin
            n_err++; $display("FAIL rr_drain got en=%b busy=%b want 0 0", wb_en, busy);
        end
    endtask

    task automatic test_backpressure();
        int writes, ch1_writes;
        bit dropped_seen;
        logic v;
        writes = 0; ch1_writes = 0; dropped_seen = 1'b0;
        do_reset();
        for (int k = 0; k < 9; k++) begin
            v = (k >= 2);
            apply((k <= 6) ? 5'd1 : 5'd0, v, 32'hA000_0000 + 32'(k),
                  (k <= 6) ? 5'(20 + k) : 5'd0, v, 32'hB000_0000 + 32'(k), 1'b0);
            if (wb_en) begin
                writes++;
                if (wb_data[31:28] == 4'hB) ch1_writes++;
                if (wb_data == 32'hB000_0008) dropped_seen = 1'b1;
            end
            if (k == 7) begin
                n_cmp++; if (exe_ready !== 2'b01 || ovf_err !== 2'b00) begin
                    n_err++; $display("FAIL bp_full got ready=%b ovf=%b want 01 00", exe_ready, ovf_err);
                end
            end
            if (k == 8) begin
                n_cmp++; if (ovf_err !== 2'b10) begin
                    n_err++; $display("FAIL bp_ovf got %b want 10", ovf_err);
                end
            end
        end
        for (int k = 0; k < 20; k++) begin
            idle();
            if (wb_en) begin
                writes++;
                if (wb_data[31:28] == 4'hB) ch1_writes++;
                if (wb_data == 32'hB000_0008) dropped_seen = 1'b1;
            end
        end
        n_cmp++; if (writes != 13 || ch1_writes != 6) begin
            n_err++; $display("FAIL bp_writes got total=%0d ch1=%0d want 13 6", writes, ch1_writes);
        end
        n_cmp++; if (dropped_seen) begin
            n_err++; $display("FAIL bp_dropped_written got 1 want 0");
        end
        apply(5'd0, 1'b0, 32'd0, 5'd0, 1'b0, 32'd0, 1'b1);
        n_cmp++; if (ovf_err !== 2'b10) begin
            n_err++; $display("FAIL bp_ovf_after_flush got %b want 10", ovf_err);
        end
    endtask

    task automatic test_flush();
        bit leaked;
        leaked = 1'b0;
        do_reset();
        apply(5'd1, 1'b0, 32'd0, 5'd21, 1'b0, 32'd0, 1'b0);
        apply(5'd2, 1'b0, 32'd0, 5'd22, 1'b0, 32'd0, 1'b0);
        apply(5'd0, 1'b1, 32'hC000_0001, 5'd0, 1'b1, 32'hC100_0001, 1'b0);
        apply(5'd7, 1'b1, 32'hC000_0002, 5'd0, 1'b1, 32'hC100_0002, 1'b0);
        n_cmp++; if (wb_en !== 1'b1 || wb_data !== 32'hC000_0001 || busy !== 1'b1) begin
            n_err++; $display("FAIL flush_pre got en=%b data=%h busy=%b want 1 c0000001 1", wb_en, wb_data, busy);
        end
        apply(5'd0, 1'b1, 32'hC000_0003, 5'd0, 1'b1, 32'hC100_0003, 1'b1);
        n_cmp++; if (wb_en !== 1'b0 || busy !== 1'b0 || exe_ready !== 2'b11) begin
            n_err++; $display("FAIL flush_state got en=%b busy=%b ready=%b want 0 0 11", wb_en, busy, exe_ready);
        end
        apply(5'd0, 1'b1, 32'hC000_0004, 5'd0, 1'b0, 32'd0, 1'b0);
        n_cmp++; if (busy !== 1'b0) begin
            n_err++; $display("FAIL flush_pipe_cleared got busy=%b want 0", busy);
        end
        for (int k = 0; k < 4; k++) begin
            idle();
            if (wb_en) leaked = 1'b1;
        end
        n_cmp++; if (leaked) begin
            n_err++; $display("FAIL flush_leak got a write want none");
        end
    endtask

    task automatic test_async_reset();
        do_reset();
        apply(5'd0, 1'b0, 32'd0, 5'd12, 1'b0, 32'd0, 1'b0);
        idle();
        apply(5'd0, 1'b0, 32'd0, 5'd0, 1'b1, 32'h1234_5678, 1'b0);
        idle();
        n_cmp++; if (wb_en !== 1'b1 || wb_addr !== 5'd12 || wb_data !== 32'h1234_5678) begin
            n_err++; $display("FAIL arst_pre got en=%b addr=%0d data=%h want 1 12 12345678", wb_en, wb_addr, wb_data);
        end
        #2;
        reset_n = 1'b0;
        #1;
        n_cmp++; if (wb_en !== 1'b0 || wb_addr !== 5'd0 || wb_data !== 32'd0) begin
            n_err++; $display("FAIL arst_immediate got en=%b addr=%0d data=%h want 0 0 0", wb_en, wb_addr, wb_data);
        end
        idle();
        reset_n = 1'b1;
    endtask

    initial begin
        test_reset();
        test_single();
        test_x0();
        test_round_robin();
        test_backpressure();
        test_flush();
        test_async_reset();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/wb_multi_arbiter.md
Name: wb_multi_arbiter

Overview:
- Parametrised successor to the single-channel writeback stage.
- Accepts results from NUM_CH execution channels and aligns each channel's decode-time destination register to its result through a RD_DELAY-deep pipe.
- Buffers each result in a per-channel FIFO with backpressure, then round-robin arbitrates onto the single register-file write port.
- Sits between the execute units and the register file; writes to x0 are suppressed.

Parameters:
- NUM_CH, 2, number of execution channels (1..4)
- DATA_WIDTH, 32, result width
- REG_ADDR_WIDTH, 5, register address width
- FIFO_DEPTH, 4, entries per channel FIFO (power of two, >=2)
- RD_DELAY, 2, cycles between dec_rd capture and the matching exe_valid (1..4)

Ports:
- clk  in  1  clock, rising edge
- reset_n  in  1  asynchronous, active-low reset
- flush  in  1  synchronous pipeline flush
- dec_rd  in  NUM_CH*REG_ADDR_WIDTH  per-channel destination register from decode; channel c occupies slice c
- exe_valid  in  NUM_CH  per-channel result valid
- exe_data  in  NUM_CH*DATA_WIDTH  per-channel result
- exe_ready  out  NUM_CH  FIFO c can accept a result
- wb_addr  out  REG_ADDR_WIDTH  register-file write address
- wb_data  out  DATA_WIDTH  register-file write data
- wb_en  out  1  register-file write enable
- busy  out  1  any FIFO non-empty
- ovf_err  out  NUM_CH  sticky: result arrived while exe_ready[c]=0

Behaviour:
- Reset (reset_n=0, asynchronous):
  - wb_addr=0, wb_data=0, wb_en=0, ovf_err=0.
  - All delay stages=0 and all FIFOs empty, so exe_ready=all ones and busy=0.
  - Round-robin pointer = NUM_CH-1, so channel 0 has first priority.
  - Reset asserted mid-operation discards every buffered entry.
- Rd alignment:
  - dec_rd[c] is shifted through RD_DELAY registers every cycle, unconditionally.
  - The result present with exe_valid[c] at edge E pairs with the dec_rd[c] sampled at edge E-RD_DELAY.
- Push:
  - At edge E, if exe_valid[c] & exe_ready[c] & (aligned rd != 0), {rd, data} is written to FIFO c.
  - An aligned rd of 0 is accepted and discarded: no FIFO entry, no write, and ovf_err is not affected.
- exe_ready[c] = (count[c] < FIFO_DEPTH), derived from registered state only.
  - A full FIFO shows ready=0 even in a cycle where it is popped; there is no combinational path from the arbiter.
- Overflow: exe_valid[c] & !exe_ready[c] & (rd != 0) drops the result and sets ovf_err[c]. ovf_err stays set until reset.
- Arbitration (each cycle):
  - Among non-empty FIFOs, grant the first channel found searching from pointer+1 modulo NUM_CH.
  - On a grant: pop the head entry, pointer <= granted index, and at the next edge wb_addr/wb_data <= head and wb_en <= 1.
  - With no grant: wb_en <= 0 and wb_addr/wb_data hold their previous values.
- Latency:
  - Push at edge E; wb_en is high after edge E+1 at the earliest (2 edges from exe_valid sampling).
  - A FIFO that is empty when pushed cannot be popped at the same edge.
- Throughput: one write per cycle in total. Push and pop on the same FIFO at the same edge leave count unchanged.
- Wrap-around: FIFO pointers are log2(FIFO_DEPTH) bits and wrap modulo depth. count is log2(FIFO_DEPTH)+1 bits.
- Flush:
  - At the edge where flush=1, all FIFOs empty and all delay stages clear to 0. wb_en <= 0, and no grant is issued that cycle.
  - exe_valid during the flush cycle is ignored.
  - The pointer and ovf_err are unaffected. Flush takes priority over push and pop.
- busy = OR of the non-empty flags, taken from registered counts.

Decomposition:
- Package wb_pkg holds:
  - default DATA_WIDTH/REG_ADDR_WIDTH values shared with system_param
  - a helper function for the next round-robin index
  - the packed entry type {rd, data} of width REG_ADDR_WIDTH+DATA_WIDTH
- Sub-module wb_chan_fifo: a synchronous FIFO with push, pop, flush, full, empty and count, instantiated NUM_CH times through generate.
- The delay pipe, arbiter and output register live in the top module.

Test Plan:
- Reset then single result:
  - Drive dec_rd[0]=5, then exe_valid[0]=1 with data 0xDEADBEEF two cycles later.
  - Required: wb_en=1, wb_addr=5, wb_data=0xDEADBEEF after the second edge from exe_valid; busy falls afterwards.
- x0 suppression: channel 0 result with aligned rd=0 -> wb_en stays 0, FIFO count stays 0, ovf_err=0.
- Round-robin:
  - Both channels push every cycle: ch0 rd=1,2,3 and ch1 rd=9,10,11.
  - Required write order 1,9,2,10,3,11 (ch0 first after reset), with wb_en continuously high.
- Full/backpressure, FIFO_DEPTH=4:
  - Push 4 results on ch1 while ch0 is continuously fed and wins alternately, so ch1 fills.
  - Required: exe_ready[1]=0 when count=4; a fifth valid sets ovf_err[1]=1 and that data never appears on wb_data; ovf_err stays set after flush.
- Flush mid-stream:
  - With 3 entries buffered, assert flush for one cycle.
  - Required: wb_en=0 the following cycle, busy=0, exe_ready all ones, and none of the 3 entries is ever written.
- Async reset mid-operation: drop reset_n between clock edges while wb_en=1 -> wb_en, wb_addr and wb_data go to 0 immediately, without waiting for a clock edge.
